// File: rtl/pipe_trace_buffer.sv
// Architectural trace recorder: timestamps WB register writes and MEM stores into a FIFO,
// appends an end marker on halt/budget. Optional PC-change logging under PIPE_TRACE_PC_EN.
module pipe_trace_buffer #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned CW          = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_CYCLES = 4,
  parameter int unsigned MAX_CYCLES  = 1000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       arm_i,
  input  logic [AW-1:0]              pc_i,
  input  logic                       wb_en_i,
  input  logic [4:0]                 wb_addr_i,
  input  logic [DW-1:0]              wb_data_i,
  input  logic                       st_en_i,
  input  logic [AW-1:0]              st_addr_i,
  input  logic [DW-1:0]              st_data_i,
  output logic                       tr_valid_o,
  input  logic                       tr_ready_i,
  output logic [2+CW+AW+DW-1:0]      tr_data_o,
  output logic [1:0]                 state_o,
  output logic [CW-1:0]              cycle_o,
  output logic [7:0]                 drop_cnt_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned FW  = $clog2(DEPTH+1);
  localparam int unsigned HW  = $clog2(HALT_CYCLES+1);
  localparam int unsigned HCW = HW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPT = 2'd1, S_MARK = 2'd2, S_DONE = 2'd3} state_t;

  typedef struct packed {
    logic [1:0]    kind;
    logic [CW-1:0] cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cycle_q, cycle_d;
  logic [7:0]     drop_q, drop_d;
  logic [FW-1:0]  fill_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           skid_vld_q, skid_vld_d;
  entry_t         skid_q, skid_d;
  logic [AW-1:0]  pc_prev_q;
  logic [HW-1:0]  halt_cnt_q, halt_cnt_d;
  logic [AW-1:0]  mark_pc_q, mark_pc_d;
  logic           mark_budget_q, mark_budget_d;
  entry_t         mem_q [DEPTH];

  logic           push, pop, can_push, flush;
  entry_t         push_data;
  logic [1:0]     ndrop;
  logic [8:0]     drop_sum;
  logic [HCW-1:0] eq_run;
  logic           halt_hit, budget_hit;

  function automatic entry_t mk_entry(logic [1:0] k, logic [CW-1:0] c,
                                      logic [AW-1:0] a, logic [DW-1:0] d);
    entry_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  assign pop        = (fill_q != '0) && tr_ready_i;
  assign can_push   = (fill_q != FW'(DEPTH)) || pop;
  assign eq_run     = (pc_i == pc_prev_q) ? ({1'b0, halt_cnt_q} + HCW'(1)) : '0;
  assign halt_hit   = eq_run >= HCW'(HALT_CYCLES - 1);
  assign budget_hit = cycle_q == CW'(MAX_CYCLES - 1);

  // Next-state, single write-port arbitration and drop accounting
  always_comb begin
    state_d       = state_q;
    cycle_d       = cycle_q;
    drop_d        = drop_q;
    skid_vld_d    = skid_vld_q;
    skid_d        = skid_q;
    halt_cnt_d    = halt_cnt_q;
    mark_pc_d     = mark_pc_q;
    mark_budget_d = mark_budget_q;
    push          = 1'b0;
    push_data     = '0;
    flush         = 1'b0;
    ndrop         = 2'd0;
    drop_sum      = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_i) begin
          flush      = 1'b1;
          cycle_d    = '0;
          drop_d     = '0;
          halt_cnt_d = '0;
          skid_vld_d = 1'b0;
          state_d    = S_CAPT;
        end
      end
      S_CAPT: begin
        cycle_d    = cycle_q + CW'(1);
        halt_cnt_d = HW'(eq_run);
        if (skid_vld_q) begin
          if (can_push) begin
            push       = 1'b1;
            push_data  = skid_q;
            skid_vld_d = 1'b0;
          end
          if (wb_en_i) ndrop = ndrop + 2'd1;
          if (st_en_i) ndrop = ndrop + 2'd1;
        end else if (wb_en_i) begin
          if (can_push) begin
            push      = 1'b1;
            push_data = mk_entry(2'b00, cycle_q, AW'(wb_addr_i), wb_data_i);
          end else begin
            ndrop = ndrop + 2'd1;
          end
          if (st_en_i) begin
            skid_vld_d = 1'b1;
            skid_d     = mk_entry(2'b01, cycle_q, st_addr_i, st_data_i);
          end
        end else if (st_en_i) begin
          if (can_push) begin
            push      = 1'b1;
            push_data = mk_entry(2'b01, cycle_q, st_addr_i, st_data_i);
          end else begin
            skid_vld_d = 1'b1;
            skid_d     = mk_entry(2'b01, cycle_q, st_addr_i, st_data_i);
          end
        end
`ifdef PIPE_TRACE_PC_EN
        if (pc_i != pc_prev_q) begin
          if (!skid_vld_q && !wb_en_i && !st_en_i && can_push) begin
            push      = 1'b1;
            push_data = mk_entry(2'b10, cycle_q, pc_i, '0);
          end else begin
            ndrop = ndrop + 2'd1;
          end
        end
`endif
        drop_sum = {1'b0, drop_q} + 9'(ndrop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (halt_hit || budget_hit) begin
          state_d       = S_MARK;
          mark_pc_d     = pc_i;
          mark_budget_d = !halt_hit;
        end
      end
      S_MARK: begin
        if (can_push) begin
          push = 1'b1;
          if (skid_vld_q) begin
            push_data  = skid_q;
            skid_vld_d = 1'b0;
          end else begin
            push_data = mk_entry(2'b11, cycle_q, mark_pc_q, DW'(mark_budget_q));
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      cycle_q       <= '0;
      drop_q        <= '0;
      fill_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      skid_vld_q    <= 1'b0;
      skid_q        <= '0;
      pc_prev_q     <= '0;
      halt_cnt_q    <= '0;
      mark_pc_q     <= '0;
      mark_budget_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      drop_q        <= drop_d;
      skid_vld_q    <= skid_vld_d;
      skid_q        <= skid_d;
      pc_prev_q     <= pc_i;
      halt_cnt_q    <= halt_cnt_d;
      mark_pc_q     <= mark_pc_d;
      mark_budget_q <= mark_budget_d;
      if (flush) begin
        fill_q   <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        fill_q <= fill_q + FW'(push) - FW'(pop);
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Entry storage; contents are masked by occupancy so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign tr_valid_o = fill_q != '0;
  assign tr_data_o  = tr_valid_o ? mem_q[rd_ptr_q] : '0;
  assign state_o    = state_q;
  assign cycle_o    = cycle_q;
  assign drop_cnt_o = drop_q;
  assign fill_o     = fill_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Randomized bench for pipe_trace_buffer against a queue-based reference model.
module tb_pipe_trace_buffer;

  localparam int AW = 32, DW = 32, CW = 16, DEPTH = 16, HALT_CYCLES = 4, MAX_CYCLES = 60;
  localparam int EW = 2 + CW + AW + DW;
  localparam int FW = $clog2(DEPTH + 1);
`ifdef PIPE_TRACE_PC_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] pc = 32'h1000;
  logic          wb_en = 1'b0;
  logic [4:0]    wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          st_en = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          tr_ready = 1'b0;
  logic          tr_valid;
  logic [EW-1:0] tr_data;
  logic [1:0]    state;
  logic [CW-1:0] cycle;
  logic [7:0]    drop_cnt;
  logic [FW-1:0] fill;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_trace_buffer #(
    .AW(AW), .DW(DW), .CW(CW), .DEPTH(DEPTH),
    .HALT_CYCLES(HALT_CYCLES), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .arm_i(arm), .pc_i(pc),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .st_en_i(st_en), .st_addr_i(st_addr), .st_data_i(st_data),
    .tr_valid_o(tr_valid), .tr_ready_i(tr_ready), .tr_data_o(tr_data),
    .state_o(state), .cycle_o(cycle), .drop_cnt_o(drop_cnt), .fill_o(fill)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            m_state, m_cycle, m_drop, m_run;
  logic [AW-1:0] m_prev, m_mark_pc;
  bit            m_mark_budget, m_skid_v;
  logic [EW-1:0] m_skid;
  logic [EW-1:0] mq[$];

  function automatic logic [EW-1:0] ent(logic [1:0] k, int c, logic [AW-1:0] a, logic [DW-1:0] d);
    return {k, CW'(c), a, d};
  endfunction

  task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cycle = 0; m_drop = 0; m_run = 0;
    m_prev = '0; m_mark_pc = '0; m_mark_budget = 0; m_skid_v = 0; m_skid = '0;
    mq.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit pop, can, pushed, skid_was, halt, budget;
    logic [EW-1:0] pe;
    int drops;
    logic [EW-1:0] evs[$];
    int kinds[$];
    pop = (mq.size() != 0) && tr_ready;
    can = (mq.size() < DEPTH) || pop;
    pushed = 0; pe = '0; drops = 0; skid_was = m_skid_v;
    case (m_state)
      0, 3: if (arm) begin
        mq.delete(); m_skid_v = 0; m_cycle = 0; m_drop = 0; m_run = 0; m_state = 1; pop = 0;
      end
      1: begin
        if (m_skid_v) begin evs.push_back(m_skid); kinds.push_back(0); end
        if (wb_en) begin evs.push_back(ent(2'b00, m_cycle, AW'(wb_addr), wb_data)); kinds.push_back(1); end
        if (st_en) begin evs.push_back(ent(2'b01, m_cycle, st_addr, st_data)); kinds.push_back(2); end
        if (PC_EN && pc != m_prev) begin evs.push_back(ent(2'b10, m_cycle, pc, '0)); kinds.push_back(3); end
        foreach (evs[i]) begin
          if (i == 0 && can) begin
            pushed = 1; pe = evs[i];
            if (kinds[i] == 0) m_skid_v = 0;
          end else if (kinds[i] == 2 && !skid_was) begin
            m_skid_v = 1; m_skid = evs[i];
          end else if (kinds[i] != 0) begin
            drops++;
          end
        end
        m_run  = (pc == m_prev) ? m_run + 1 : 0;
        halt   = m_run >= HALT_CYCLES - 1;
        budget = m_cycle == MAX_CYCLES - 1;
        if (halt || budget) begin
          m_state = 2; m_mark_pc = pc; m_mark_budget = !halt;
        end
        m_cycle++;
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      end
      2: if (can) begin
        pushed = 1;
        if (m_skid_v) begin
          pe = m_skid; m_skid_v = 0;
        end else begin
          pe = ent(2'b11, m_cycle, m_mark_pc, DW'(m_mark_budget)); m_state = 3;
        end
      end
      default: ;
    endcase
    m_prev = pc;
    if (pop) void'(mq.pop_front());
    if (pushed) mq.push_back(pe);
  endtask

  task automatic check_all();
    logic [EW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    check_eq("state", state, m_state);
    check_eq("cycle", cycle, m_cycle);
    check_eq("drop_cnt", drop_cnt, m_drop);
    check_eq("fill", fill, mq.size());
    check_eq("tr_valid", tr_valid, mq.size() != 0);
    check_eq("tr_data", tr_data, head);
  endtask

  task automatic check_reset_values(string tag);
    check_eq({tag, "_state"}, state, 0);
    check_eq({tag, "_cycle"}, cycle, 0);
    check_eq({tag, "_drop"}, drop_cnt, 0);
    check_eq({tag, "_fill"}, fill, 0);
    check_eq({tag, "_valid"}, tr_valid, 0);
    check_eq({tag, "_data"}, tr_data, 0);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    arm = 0; wb_en = 0; st_en = 0;
  endtask

  task automatic rand_inputs(int rdy_pct, int arm_pct);
    arm      = $urandom_range(99) < arm_pct;
    wb_en    = $urandom_range(99) < 50;
    wb_addr  = 5'($urandom);
    wb_data  = $urandom;
    st_en    = $urandom_range(99) < 40;
    st_addr  = $urandom;
    st_data  = $urandom;
    tr_ready = $urandom_range(99) < rdy_pct;
    if ($urandom_range(3) != 0) pc = pc + 4;
  endtask

  initial begin
    logic [AW-1:0] last_pc;
    int guard;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;

    // First register write lands at cycle 2
    arm = 1; pc = pc + 4; step(); arm = 0;
    pc = pc + 4; step();
    pc = pc + 4; step();
    wb_en = 1; wb_addr = 5'd3; wb_data = 32'd7; pc = pc + 4; step(); wb_en = 0;
    check_eq("tpA_data", tr_data, {2'b00, 16'd2, 32'd3, 32'd7});
    check_eq("tpA_fill", fill, 1);
    check_eq("tpA_valid", tr_valid, 1);

    // Same-cycle write + store at cycle 4, store follows via skid
    pc = pc + 4; step();
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'd9;
    st_en = 1; st_addr = 32'd8; st_data = 32'd11;
    pc = pc + 4; step(); quiet();
    pc = pc + 4; step();
    check_eq("tpB_fill", fill, 3);
    check_eq("tpB_drop", drop_cnt, 0);
    tr_ready = 1;
    pc = pc + 4; step();
    check_eq("tpB_head1", tr_data, {2'b00, 16'd4, 32'd5, 32'd9});
    pc = pc + 4; step();
    check_eq("tpB_head2", tr_data, {2'b01, 16'd4, 32'd8, 32'd11});
    pc = pc + 4; step();

    // Back-to-back write + store collisions
    for (int i = 0; i < 3; i++) begin
      wb_en = 1; wb_addr = 5'($urandom); wb_data = $urandom;
      st_en = 1; st_addr = $urandom; st_data = $urandom;
      pc = pc + 4; step();
    end
    quiet();
    for (int i = 0; i < 4; i++) begin pc = pc + 4; step(); end

    // Halt on stable PC
    pc = 32'h40;
    for (int i = 0; i < 4; i++) step();
    check_eq("tpD_mark", state, 2);
    step();
    check_eq("tpD_done", state, 3);
    check_eq("tpD_kind", tr_data[EW-1 -: 2], 2'b11);
    check_eq("tpD_addr", tr_data[AW+DW-1 -: AW], 32'h40);
    check_eq("tpD_data", tr_data[DW-1:0], 0);

    // Overflow under backpressure; marker waits for space
    arm = 1; tr_ready = 0; pc = pc + 4; step(); arm = 0;
    for (int i = 0; i < 20; i++) begin
      wb_en = 1; wb_addr = 5'($urandom); wb_data = $urandom;
      pc = pc + 4; step();
    end
    quiet();
    check_eq("tpE_fill", fill, 16);
    check_eq("tpE_drop", drop_cnt, 4);
    pc = pc + 4;
    for (int i = 0; i < 6; i++) step();
    check_eq("tpE_mark_wait", state, 2);
    tr_ready = 1; step();
    check_eq("tpE_done", state, 3);
    check_eq("tpE_fill_after", fill, 16);
    for (int i = 0; i < 20; i++) step();

    // Asynchronous reset mid-capture
    arm = 1; tr_ready = 0; pc = pc + 4; step(); arm = 0;
    for (int i = 0; i < 5; i++) begin
      wb_en = 1; wb_addr = 5'($urandom); wb_data = $urandom;
      pc = pc + 4; step();
    end
    quiet();
    check_eq("tpF_fill", fill, 5);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("tpF_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // Restart and run to the cycle budget
    arm = 1; tr_ready = 1; pc = pc + 4; step(); arm = 0;
    check_eq("tpF_restart_cycle", cycle, 0);
    check_eq("tpF_restart_state", state, 1);
    for (int i = 0; i < MAX_CYCLES; i++) begin
      pc = pc + 4; step();
      if (i == 0) check_eq("tpG_cycle1", cycle, 1);
    end
    last_pc = pc;
    check_eq("tpG_mark", state, 2);
    check_eq("tpG_cycle_hold", cycle, MAX_CYCLES);
    step();
    check_eq("tpG_done", state, 3);
    check_eq("tpG_marker", tr_data, {2'b11, CW'(MAX_CYCLES), last_pc, 32'd1});
    step();

    // Randomized capture episodes
    for (int ep = 0; ep < 12; ep++) begin
      quiet(); arm = 1; pc = pc + 4; step(); arm = 0;
      guard = 0;
      while (m_state != 3 && guard < 300) begin
        rand_inputs((ep % 3 == 0) ? 20 : 80, 3);
        step();
        guard++;
      end
      check_eq("episode_done", state, 3);
      quiet(); tr_ready = 1;
      for (int i = 0; i < DEPTH + 4; i++) begin
        rand_inputs(100, 0); arm = 0;
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
